// File: rtl/slon5_dout_sink.sv
// Receive end of the slon5 datapath: checks dnum sequencing, buffers results in a
// small FIFO and serializes each one as a header word plus MSW-first payload words.
module slon5_dout_sink #(
  parameter int DNUM_W     = 32,
  parameter int DOUT_W     = 256,
  parameter int SER_W      = 32,
  parameter int FIFO_DEPTH = 8,
  parameter int CNT_W      = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clear,
  input  logic              in_valid,
  input  logic [DNUM_W-1:0] in_dnum,
  input  logic [DOUT_W-1:0] in_dout,
  output logic              so_valid,
  input  logic              so_ready,
  output logic [SER_W-1:0]  so_data,
  output logic              so_last,
  output logic [31:0]       rx_cnt,
  output logic [CNT_W-1:0]  seq_err_cnt,
  output logic [CNT_W-1:0]  drop_cnt,
  output logic              seq_err,
  output logic              ovf
);

  localparam int WORDS = DOUT_W / SER_W;
  localparam int IDX_W = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int ENT_W = DNUM_W + DOUT_W;
  localparam int MAXW  = (DNUM_W > SER_W) ? DNUM_W : SER_W;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WORDS - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HDR  = 2'd1,
    ST_DATA = 2'd2
  } state_t;

  state_t              state_r, state_nxt_s;
  logic [ENT_W-1:0]    mem_r [FIFO_DEPTH];
  logic [PTR_W-1:0]    wr_ptr_r, rd_ptr_r;
  logic [PTR_W:0]      count_r;
  logic                full_s, empty_s, push_s, drop_s, pop_s;
  logic [DNUM_W-1:0]   sh_dnum_r;
  logic [DOUT_W-1:0]   sh_dout_r;
  logic [IDX_W-1:0]    idx_r;
  logic                armed_r;
  logic [DNUM_W-1:0]   exp_r;
  logic                mismatch_s;
  logic [MAXW-1:0]     hdr_ext_s;
  logic [DOUT_W-1:0]   shifted_s;

  // Full is taken from the registered count, so a same-cycle pop never rescues a write.
  assign full_s     = (count_r == (PTR_W+1)'(FIFO_DEPTH));
  assign empty_s    = (count_r == (PTR_W+1)'(0));
  assign push_s     = in_valid && !full_s && !clear;
  assign drop_s     = in_valid && full_s && !clear;
  assign mismatch_s = in_valid && !clear && armed_r && (in_dnum != exp_r);

  // FIFO storage; contents are don't-care until the pointers say otherwise.
  always_ff @(posedge clk) begin
    if (push_s) begin
      mem_r[wr_ptr_r] <= {in_dnum, in_dout};
    end
  end

  // FIFO pointers and occupancy.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      count_r  <= '0;
    end else if (clear) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      count_r  <= '0;
    end else begin
      if (push_s) wr_ptr_r <= wr_ptr_r + PTR_W'(1);
      if (pop_s)  rd_ptr_r <= rd_ptr_r + PTR_W'(1);
      case ({push_s, pop_s})
        2'b10:   count_r <= count_r + (PTR_W+1)'(1);
        2'b01:   count_r <= count_r - (PTR_W+1)'(1);
        default: count_r <= count_r;
      endcase
    end
  end

  // Serializer next-state and FIFO pop decision.
  always_comb begin
    state_nxt_s = state_r;
    pop_s       = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (!empty_s) begin
          pop_s       = 1'b1;
          state_nxt_s = ST_HDR;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_HDR: begin
        if (so_ready) state_nxt_s = ST_DATA;
        else          state_nxt_s = ST_HDR;
      end
      ST_DATA: begin
        if (so_ready && (idx_r == LAST_IDX)) state_nxt_s = ST_IDLE;
        else                                  state_nxt_s = ST_DATA;
      end
      default: state_nxt_s = ST_IDLE;
    endcase
    if (clear) begin
      state_nxt_s = ST_IDLE;
      pop_s       = 1'b0;
    end else begin
      pop_s = pop_s;
    end
  end

  // Serializer state, word index and shadow copy of the frame in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r   <= ST_IDLE;
      idx_r     <= '0;
      sh_dnum_r <= '0;
      sh_dout_r <= '0;
    end else if (clear) begin
      state_r   <= ST_IDLE;
      idx_r     <= '0;
      sh_dnum_r <= '0;
      sh_dout_r <= '0;
    end else begin
      state_r <= state_nxt_s;
      if (pop_s) {sh_dnum_r, sh_dout_r} <= mem_r[rd_ptr_r];
      if (state_r == ST_HDR && so_ready)       idx_r <= '0;
      else if (state_r == ST_DATA && so_ready) idx_r <= idx_r + IDX_W'(1);
    end
  end

  // Sequence tracker and status counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      armed_r     <= 1'b0;
      exp_r       <= '0;
      rx_cnt      <= 32'd0;
      seq_err_cnt <= '0;
      drop_cnt    <= '0;
      seq_err     <= 1'b0;
      ovf         <= 1'b0;
    end else if (clear) begin
      armed_r     <= 1'b0;
      exp_r       <= '0;
      rx_cnt      <= 32'd0;
      seq_err_cnt <= '0;
      drop_cnt    <= '0;
      seq_err     <= 1'b0;
      ovf         <= 1'b0;
    end else begin
      if (in_valid) begin
        armed_r <= 1'b1;
        exp_r   <= in_dnum + DNUM_W'(1);
      end
      if (mismatch_s) begin
        seq_err <= 1'b1;
        if (seq_err_cnt != {CNT_W{1'b1}}) seq_err_cnt <= seq_err_cnt + CNT_W'(1);
      end
      if (push_s) rx_cnt <= rx_cnt + 32'd1;
      if (drop_s) begin
        ovf <= 1'b1;
        if (drop_cnt != {CNT_W{1'b1}}) drop_cnt <= drop_cnt + CNT_W'(1);
      end
    end
  end

  assign hdr_ext_s = MAXW'(sh_dnum_r);
  assign shifted_s = sh_dout_r << (idx_r * SER_W);

  // Output word select; everything is decoded from registered state.
  always_comb begin
    so_valid = (state_r != ST_IDLE);
    so_last  = (state_r == ST_DATA) && (idx_r == LAST_IDX);
    case (state_r)
      ST_HDR:  so_data = hdr_ext_s[SER_W-1:0];
      ST_DATA: so_data = shifted_s[DOUT_W-1 -: SER_W];
      default: so_data = '0;
    endcase
  end

endmodule

// File: tb/tb_slon5_dout_sink.sv
// Directed self-checking bench for slon5_dout_sink with default parameters.
module tb_slon5_dout_sink;

  logic         clk = 1'b0;
  logic         rst_n, clear, in_valid, so_ready;
  logic [31:0]  in_dnum;
  logic [255:0] in_dout;
  logic         so_valid, so_last, seq_err, ovf;
  logic [31:0]  so_data, rx_cnt;
  logic [15:0]  seq_err_cnt, drop_cnt;
  int           vectors = 0;
  int           miscompares = 0;

  slon5_dout_sink dut (
    .clk(clk), .rst_n(rst_n), .clear(clear), .in_valid(in_valid),
    .in_dnum(in_dnum), .in_dout(in_dout), .so_valid(so_valid), .so_ready(so_ready),
    .so_data(so_data), .so_last(so_last), .rx_cnt(rx_cnt), .seq_err_cnt(seq_err_cnt),
    .drop_cnt(drop_cnt), .seq_err(seq_err), .ovf(ovf)
  );

  always #5 clk = ~clk;

  // Payload word w (0 = first sent, most significant) of result d.
  function automatic logic [31:0] wexp(input logic [31:0] d, input int w);
    logic [7:0] tag;
    tag = 8'hA0 + 8'(w);
    return {tag, d[23:0]};
  endfunction

  function automatic logic [255:0] pay(input logic [31:0] d);
    logic [255:0] p;
    for (int w = 0; w < 8; w++) p[(7-w)*32 +: 32] = wexp(d, w);
    return p;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    vectors++;
    assert (obs === expv) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic send(input logic [31:0] d);
    in_valid = 1'b1;
    in_dnum  = d;
    in_dout  = pay(d);
    step();
    in_valid = 1'b0;
  endtask

  task automatic do_clear();
    clear = 1'b1;
    step();
    clear = 1'b0;
  endtask

  // Receive one full frame with so_ready held high.
  task automatic expect_frame(input logic [31:0] d);
    int t;
    so_ready = 1'b1;
    for (int w = 0; w < 9; w++) begin
      t = 0;
      while (!so_valid && t < 50) begin
        step();
        t++;
      end
      chk("frame_valid", so_valid, 1);
      chk(w == 0 ? "hdr_word" : "data_word", so_data, (w == 0) ? d : wexp(d, w - 1));
      chk("so_last", so_last, (w == 8) ? 1 : 0);
      step();
    end
  endtask

  initial begin
    int  w;
    logic was_valid, rdy;
    rst_n = 1'b0; clear = 1'b0; in_valid = 1'b0; so_ready = 1'b0;
    in_dnum = 32'd0; in_dout = '0;
    step(); step();
    chk("rst_so_valid", so_valid, 0);
    chk("rst_so_last", so_last, 0);
    chk("rst_so_data", so_data, 0);
    chk("rst_rx_cnt", rx_cnt, 0);
    chk("rst_seq_err_cnt", seq_err_cnt, 0);
    chk("rst_drop_cnt", drop_cnt, 0);
    chk("rst_flags", {seq_err, ovf}, 0);
    rst_n = 1'b1;
    step();

    // In-order results and two-cycle header latency
    send(32'd5);
    chk("lat_t1_valid", so_valid, 0);
    step();
    chk("lat_t2_valid", so_valid, 1);
    chk("lat_t2_hdr", so_data, 5);
    send(32'd6); send(32'd7); send(32'd8);
    expect_frame(32'd5); expect_frame(32'd6); expect_frame(32'd7); expect_frame(32'd8);
    step();
    chk("t1_rx_cnt", rx_cnt, 4);
    chk("t1_seq_err", seq_err, 0);
    chk("t1_seq_err_cnt", seq_err_cnt, 0);
    chk("t1_idle", so_valid, 0);

    // One gap counts once
    so_ready = 1'b0;
    do_clear();
    send(32'd10); send(32'd11); send(32'd13); send(32'd14);
    chk("gap_seq_err_cnt", seq_err_cnt, 1);
    chk("gap_seq_err", seq_err, 1);
    expect_frame(32'd10); expect_frame(32'd11); expect_frame(32'd13); expect_frame(32'd14);
    chk("gap_rx_cnt", rx_cnt, 4);

    // dnum wrap-around is not an error
    so_ready = 1'b0;
    do_clear();
    chk("clr_seq_err", seq_err, 0);
    send(32'hFFFF_FFFF); send(32'd0);
    chk("wrap_seq_err_cnt", seq_err_cnt, 0);
    expect_frame(32'hFFFF_FFFF); expect_frame(32'd0);

    // Overflow: one in shadow, eight stored, tenth dropped
    so_ready = 1'b0;
    do_clear();
    for (int i = 0; i < 10; i++) send(32'd100 + 32'(i));
    chk("ovf_drop_cnt", drop_cnt, 1);
    chk("ovf_flag", ovf, 1);
    chk("ovf_rx_cnt", rx_cnt, 9);
    chk("ovf_seq_err_cnt", seq_err_cnt, 0);
    for (int i = 0; i < 9; i++) expect_frame(32'd100 + 32'(i));
    step(); step();
    chk("ovf_drained", so_valid, 0);

    // so_ready toggling: held data during stalls, MSW first
    so_ready = 1'b0;
    do_clear();
    send(32'd200);
    w = 0;
    for (int c = 0; c < 60 && w < 9; c++) begin
      rdy = 1'(c % 2);
      so_ready = rdy;
      was_valid = so_valid;
      if (was_valid) begin
        chk("tog_word", so_data, (w == 0) ? 32'd200 : wexp(32'd200, w - 1));
        chk("tog_last", so_last, (w == 8) ? 1 : 0);
      end
      step();
      if (was_valid && rdy) w++;
    end
    chk("tog_frame_done", w, 9);
    so_ready = 1'b0;

    // clear mid-frame at idx 3, with a same-cycle in_valid that must be ignored
    do_clear();
    send(32'd300);
    step();
    chk("abort_hdr", so_data, 300);
    so_ready = 1'b1;
    step(); step(); step(); step();
    chk("abort_at_idx3", so_data, wexp(32'd300, 3));
    so_ready = 1'b0;
    clear = 1'b1;
    in_valid = 1'b1; in_dnum = 32'd999; in_dout = pay(32'd999);
    step();
    clear = 1'b0; in_valid = 1'b0;
    chk("abort_valid", so_valid, 0);
    chk("abort_counters", {rx_cnt, seq_err_cnt, drop_cnt}, 0);
    chk("abort_flags", {seq_err, ovf}, 0);
    step(); step();
    chk("abort_ignored_in", so_valid, 0);
    send(32'd500);
    chk("rearm_seq_err", seq_err, 0);
    chk("rearm_rx_cnt", rx_cnt, 1);
    expect_frame(32'd500);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/slon5_dout_sink.md
Name: slon5_dout_sink

Overview:
- Receive end of the slon5 datapath: consumes the (dnum, dout) result stream emitted by slon5_test and checks dnum sequencing.
- Buffers results in a small FIFO and serializes each one onto a narrow valid/ready stream for host readback (UART/JTAG bridge, debug capture).
- Replaces bench-side ad-hoc monitoring of dout/dnum in hardware builds.

Parameters:
- DNUM_W, 32, width of result tag (matches Dnum_t)
- DOUT_W, 256, width of result payload (matches Dout_t); must be a multiple of SER_W
- SER_W, 32, serial output word width
- FIFO_DEPTH, 8, result FIFO entries; power of two, >= 2
- CNT_W, 16, width of error/drop counters

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- clear  in  1  synchronous clear of counters, sticky flags, FIFO, sequence tracker
- in_valid  in  1  result valid strobe; no backpressure toward the pipeline
- in_dnum  in  DNUM_W  result tag
- in_dout  in  DOUT_W  result payload
- so_valid  out  1  serial word valid
- so_ready  in  1  serial word accept
- so_data  out  SER_W  serial word
- so_last  out  1  final word of a result frame
- rx_cnt  out  32  results accepted into the FIFO, wraps
- seq_err_cnt  out  CNT_W  sequence errors, saturating
- drop_cnt  out  CNT_W  results dropped on FIFO full, saturating
- seq_err  out  1  sticky: any sequence error since reset/clear
- ovf  out  1  sticky: any drop since reset/clear

Behaviour:
- Reset (async, rst_n=0): all outputs 0, FIFO empty, FSM=IDLE, tracker unarmed. The clear input produces the same state synchronously.
- Sequence tracker:
  - First in_valid after reset/clear arms the tracker with exp = in_dnum+1. No error on that first result.
  - Afterwards, each in_valid compares in_dnum with exp. On mismatch: seq_err_cnt++ (saturating at all-ones) and seq_err<=1.
  - exp <= in_dnum+1 (mod 2^DNUM_W) regardless of match, so one gap counts once.
  - The check runs whether the result is stored or dropped.
- FIFO write: in_valid && !full stores {dnum,dout} and rx_cnt++. in_valid && full drops the result, drop_cnt++ (saturating), ovf<=1.
  - Full is evaluated before a same-cycle pop, so a simultaneous pop does not rescue the write.
- Serializer FSM:
  - IDLE: if FIFO not empty, pop the head into a shadow register and go to HDR. The pop happens on the IDLE->HDR transition.
  - HDR: so_valid=1, so_data=dnum zero-extended or truncated to SER_W, so_last=0. On so_ready go to DATA with idx=0.
  - DATA: so_valid=1, so_data=payload word idx, most-significant first. so_last=1 when idx==DOUT_W/SER_W-1.
  - On so_ready in DATA: idx++; after the last word go to IDLE.
  - Frame length is 1+DOUT_W/SER_W words. Default = 9.
- Output rules:
  - so_data and so_last are stable while so_valid && !so_ready.
  - so_valid never drops without a handshake.
  - Minimum gap between frames is 1 cycle (the IDLE cycle).
- Latency: an in_valid at cycle t into an empty FIFO with an idle FSM gives the HDR word on so_valid at t+2.
- clear mid-frame aborts the frame: so_valid=0 next cycle, FSM=IDLE. clear takes priority over a same-cycle in_valid, which is ignored.
- Counters: rx_cnt wraps at 2^32. seq_err_cnt and drop_cnt saturate.

Test Plan:
- Reset, then 4 results dnum=5,6,7,8 with so_ready=1 -> 4 frames of 9 words; HDR words 5..8; so_last on every 9th word; rx_cnt=4; seq_err=0.
- dnum sequence 10,11,13,14 -> seq_err_cnt=1, seq_err=1; all 4 frames emitted.
- dnum=0xFFFFFFFF then 0 -> no error (wrap-around); seq_err_cnt=0.
- so_ready=0, 10 back-to-back results with FIFO_DEPTH=8:
  - 1 result popped to the shadow register, 8 stored, 1 dropped -> drop_cnt=1, ovf=1, rx_cnt=9.
  - Release so_ready -> 9 frames emitted in order.
- so_ready toggling 1/0 every cycle -> so_data held steady during stalls; payload word order MSW first.
- clear asserted in DATA state at idx=3 -> so_valid=0 next cycle; all counters and flags 0; next result re-arms the tracker with no error.
